elevator_request_scheduler: RTL and testbench



---
 rtl/elevator_pkg.sv | 23 ++
 rtl/elevator_request_scheduler_if.sv | 27 ++
 rtl/call_sync_edge.sv | 33 +++
 rtl/elevator_request_scheduler.sv | 217 +++++++++++++++++++++
 tb/tb_elevator_request_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared floor sizing and state encodings for the elevator blocks
// Purpose: default floor count/width, dwell length, scheduler FSM states and
//          the car FSM's IDLE/MOVING encoding shared with elevator_state_machine.
// Ports:   none (package).
package elevator_pkg;

  localparam int NUM_FLOORS   = 10;
  localparam int FLOOR_W      = 4;
  localparam int DWELL_CYCLES = 8;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_SERVE_UP   = 2'd1,
    S_SERVE_DOWN = 2'd2,
    S_DOOR       = 2'd3
  } sched_state_t;

  typedef enum logic {
    IDLE   = 1'b0,
    MOVING = 1'b1
  } car_state_t;

endpackage

// File: rtl/elevator_request_scheduler_if.sv
// rtl/elevator_request_scheduler_if.sv - scheduler <-> car state machine link
// Purpose: carries the car position/idle status to the scheduler and the
//          target floor back to the car.
// Signals: current_floor (car -> sched), car_idle (car -> sched),
//          requested_floor (sched -> car).
// Modports: master = scheduler side, slave = car state machine side.
interface elevator_request_scheduler_if #(
  parameter int FLOOR_W = elevator_pkg::FLOOR_W
);

  logic [FLOOR_W-1:0] current_floor;
  logic               car_idle;
  logic [FLOOR_W-1:0] requested_floor;

  modport master (
    input  current_floor,
    input  car_idle,
    output requested_floor
  );

  modport slave (
    output current_floor,
    output car_idle,
    input  requested_floor
  );

endinterface

// File: rtl/call_sync_edge.sv
// rtl/call_sync_edge.sv - per-button 2-flop synchroniser with rising-edge detect
// Purpose: brings raw asynchronous call buttons into clk and emits a one-cycle
//          pulse per press, so a held button yields a single call.
// Ports:   clk, reset (sync, active-high), btn[WIDTH] raw buttons,
//          rise[WIDTH] one-cycle press pulses.
module call_sync_edge #(
  parameter int WIDTH = elevator_pkg::NUM_FLOORS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

endmodule

// File: rtl/elevator_request_scheduler.sv
// rtl/elevator_request_scheduler.sv - SCAN call scheduler feeding the car state machine
// Purpose: latches synchronised hall/car calls into a pending bitmap, picks the
//          next target floor with a SCAN sweep, retires a call on arrival and
//          holds the door open for a dwell period.
// Ports:   clk, reset (sync, active-high), btn[NUM_FLOORS] raw call buttons,
//          car (master: current_floor/car_idle in, requested_floor out),
//          pending[NUM_FLOORS] outstanding calls, dir_up sweep direction,
//          door_open high during dwell.
module elevator_request_scheduler #(
  parameter int NUM_FLOORS   = elevator_pkg::NUM_FLOORS,
  parameter int FLOOR_W      = elevator_pkg::FLOOR_W,
  parameter int DWELL_CYCLES = elevator_pkg::DWELL_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] btn,
  elevator_request_scheduler_if.master car,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  door_open
);

  import elevator_pkg::*;

  localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

  sched_state_t state;
  sched_state_t state_next;

  logic [FLOOR_W-1:0]    req_q;
  logic [FLOOR_W-1:0]    req_next;
  logic                  dir_next;
  logic [CNT_W-1:0]      dwell_cnt;
  logic [CNT_W-1:0]      dwell_next;
  logic [NUM_FLOORS-1:0] rise;
  logic [NUM_FLOORS-1:0] set_mask;
  logic [NUM_FLOORS-1:0] clr_mask;
  logic [NUM_FLOORS-1:0] pending_next;
  logic [NUM_FLOORS-1:0] cur_bit;
  logic [FLOOR_W-1:0]    cur;
  logic                  in_range;
  logic                  at_target;

  // Search results are {found, floor}.
  logic [FLOOR_W:0] up_any;
  logic [FLOOR_W:0] dn_any;
  logic [FLOOR_W:0] up_scan;
  logic [FLOOR_W:0] dn_scan;
  logic [FLOOR_W:0] ahead;
  logic [FLOOR_W:0] behind;

  call_sync_edge #(.WIDTH(NUM_FLOORS)) u_sync (
    .clk   (clk),
    .reset (reset),
    .btn   (btn),
    .rise  (rise)
  );

  // Lowest pending floor above 'from' (or equal to it when incl is set).
  // Scanning downwards lets the last hit be the lowest one.
  function automatic logic [FLOOR_W:0] find_above(
    input logic [NUM_FLOORS-1:0] calls,
    input logic [FLOOR_W-1:0]    from,
    input logic                  incl
  );
    logic [FLOOR_W:0] r;
    r = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (calls[i] && ((FLOOR_W'(i) > from) || (incl && (FLOOR_W'(i) == from)))) begin
        r = {1'b1, FLOOR_W'(i)};
      end
    end
    return r;
  endfunction

  // Highest pending floor below 'from' (or equal to it when incl is set).
  function automatic logic [FLOOR_W:0] find_below(
    input logic [NUM_FLOORS-1:0] calls,
    input logic [FLOOR_W-1:0]    from,
    input logic                  incl
  );
    logic [FLOOR_W:0] r;
    r = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (calls[i] && ((FLOOR_W'(i) < from) || (incl && (FLOOR_W'(i) == from)))) begin
        r = {1'b1, FLOOR_W'(i)};
      end
    end
    return r;
  endfunction

  assign cur       = car.current_floor;
  assign in_range  = ({1'b0, cur} < (FLOOR_W + 1)'(NUM_FLOORS));
  assign cur_bit   = in_range ? (NUM_FLOORS'(1) << cur) : '0;
  assign at_target = car.car_idle && (cur == req_q);

  assign up_any  = find_above(pending, cur, 1'b0);
  assign dn_any  = find_below(pending, cur, 1'b0);
  // While serving, a call at the floor the car is standing on counts as
  // "ahead" so a stopped car picks it up before moving on.
  assign up_scan = find_above(pending, cur, car.car_idle);
  assign dn_scan = find_below(pending, cur, car.car_idle);
  assign ahead   = dir_up ? up_any : dn_any;
  assign behind  = dir_up ? dn_any : up_any;

  always_comb begin
    state_next = state;
    req_next   = cur;
    dir_next   = dir_up;
    dwell_next = '0;
    clr_mask   = '0;

    if (!in_range) begin
      state_next = S_IDLE;
      req_next   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|(pending & cur_bit)) begin
            clr_mask   = cur_bit;
            state_next = S_DOOR;
          end else if (up_any[FLOOR_W]) begin
            state_next = S_SERVE_UP;
            dir_next   = 1'b1;
            req_next   = up_any[FLOOR_W-1:0];
          end else if (dn_any[FLOOR_W]) begin
            state_next = S_SERVE_DOWN;
            dir_next   = 1'b0;
            req_next   = dn_any[FLOOR_W-1:0];
          end
        end

        S_SERVE_UP: begin
          if (at_target) begin
            clr_mask   = cur_bit;
            state_next = S_DOOR;
            dir_next   = 1'b1;
          end else if (up_scan[FLOOR_W]) begin
            req_next = up_scan[FLOOR_W-1:0];
          end else if (dn_any[FLOOR_W]) begin
            state_next = S_SERVE_DOWN;
            dir_next   = 1'b0;
            req_next   = dn_any[FLOOR_W-1:0];
          end else begin
            state_next = S_IDLE;
          end
        end

        S_SERVE_DOWN: begin
          if (at_target) begin
            clr_mask   = cur_bit;
            state_next = S_DOOR;
            dir_next   = 1'b0;
          end else if (dn_scan[FLOOR_W]) begin
            req_next = dn_scan[FLOOR_W-1:0];
          end else if (up_any[FLOOR_W]) begin
            state_next = S_SERVE_UP;
            dir_next   = 1'b1;
            req_next   = up_any[FLOOR_W-1:0];
          end else begin
            state_next = S_IDLE;
          end
        end

        S_DOOR: begin
          if (|(rise & cur_bit)) begin
            dwell_next = '0;
          end else if (dwell_cnt == DWELL_LAST) begin
            if (ahead[FLOOR_W]) begin
              state_next = dir_up ? S_SERVE_UP : S_SERVE_DOWN;
              req_next   = ahead[FLOOR_W-1:0];
            end else if (behind[FLOOR_W]) begin
              state_next = dir_up ? S_SERVE_DOWN : S_SERVE_UP;
              dir_next   = ~dir_up;
              req_next   = behind[FLOOR_W-1:0];
            end else begin
              state_next = S_IDLE;
            end
          end else begin
            dwell_next = dwell_cnt + 1'b1;
          end
        end

        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  // Presses at the floor whose door is open are absorbed; a clear beats a
  // simultaneous set on the same floor.
  assign set_mask     = rise & ~((state == S_DOOR) ? cur_bit : '0);
  assign pending_next = (pending | set_mask) & ~clr_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      req_q     <= '0;
      pending   <= '0;
      dir_up    <= 1'b1;
      door_open <= 1'b0;
      dwell_cnt <= '0;
    end else begin
      state     <= state_next;
      req_q     <= req_next;
      pending   <= pending_next;
      dir_up    <= dir_next;
      door_open <= (state_next == S_DOOR);
      dwell_cnt <= dwell_next;
    end
  end

  assign car.requested_floor = req_q;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// tb/tb_elevator_request_scheduler.sv - self-checking bench for elevator_request_scheduler
module tb_elevator_request_scheduler;

  localparam int NF = 10;
  localparam int DW = 8;
  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_DOWN = 2;
  localparam int M_DOOR = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NF-1:0] btn = '0;
  logic [3:0]    cur = 4'd0;
  logic          idle = 1'b1;
  logic [NF-1:0] pend;
  logic          dir_up;
  logic          door_open;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  elevator_request_scheduler_if #(.FLOOR_W(4)) bus ();
  assign bus.current_floor = cur;
  assign bus.car_idle      = idle;

  elevator_request_scheduler #(
    .NUM_FLOORS   (NF),
    .FLOOR_W      (4),
    .DWELL_CYCLES (DW)
  ) dut (
    .clk       (clk),
    .reset     (rst),
    .btn       (btn),
    .car       (bus),
    .pending   (pend),
    .dir_up    (dir_up),
    .door_open (door_open)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit            m_pend [NF];
  int            m_req, m_mode, m_cnt;
  bit            m_dir, m_door;
  logic [NF-1:0] h1, h2, h3;   // button samples from 1, 2, 3 edges ago

  function automatic int m_above(int c, bit incl);
    for (int f = 0; f < NF; f++)
      if (m_pend[f] && (f > c || (incl && f == c))) return f;
    return -1;
  endfunction

  function automatic int m_below(int c, bit incl);
    for (int f = NF - 1; f >= 0; f--)
      if (m_pend[f] && (f < c || (incl && f == c))) return f;
    return -1;
  endfunction

  function automatic logic [NF-1:0] m_pend_vec();
    logic [NF-1:0] v;
    for (int f = 0; f < NF; f++) v[f] = m_pend[f];
    return v;
  endfunction

  always @(posedge clk) begin : model
    int c, a, b, ah, bh, clr, nmode, nreq, ncnt;
    bit ndir;
    logic [NF-1:0] press, setm;
    if (rst) begin
      for (int f = 0; f < NF; f++) m_pend[f] = 1'b0;
      m_req = 0; m_mode = M_IDLE; m_cnt = 0; m_dir = 1'b1; m_door = 1'b0;
      h1 = '0; h2 = '0; h3 = '0;
    end else begin
      // a press first sampled at edge k becomes a call at edge k+2
      press = h2 & ~h3;
      h3 = h2; h2 = h1; h1 = btn;
      c = int'(cur);
      clr = -1; setm = press;
      nmode = m_mode; nreq = c; ndir = m_dir; ncnt = 0;
      if (c >= NF) begin
        nmode = M_IDLE; nreq = 0;
      end else begin
        a = m_above(c, 1'b0);
        b = m_below(c, 1'b0);
        if (m_mode == M_DOOR) setm[c] = 1'b0;
        case (m_mode)
          M_IDLE: begin
            if (m_pend[c]) begin clr = c; nmode = M_DOOR; end
            else if (a >= 0) begin nmode = M_UP; ndir = 1'b1; nreq = a; end
            else if (b >= 0) begin nmode = M_DOWN; ndir = 1'b0; nreq = b; end
          end
          M_UP: begin
            if (idle && c == m_req) begin clr = c; nmode = M_DOOR; ndir = 1'b1; end
            else begin
              ah = m_above(c, idle);
              if (ah >= 0) nreq = ah;
              else if (b >= 0) begin nmode = M_DOWN; ndir = 1'b0; nreq = b; end
              else nmode = M_IDLE;
            end
          end
          M_DOWN: begin
            if (idle && c == m_req) begin clr = c; nmode = M_DOOR; ndir = 1'b0; end
            else begin
              ah = m_below(c, idle);
              if (ah >= 0) nreq = ah;
              else if (a >= 0) begin nmode = M_UP; ndir = 1'b1; nreq = a; end
              else nmode = M_IDLE;
            end
          end
          default: begin
            if (press[c]) ncnt = 0;
            else if (m_cnt == DW - 1) begin
              ah = m_dir ? a : b;
              bh = m_dir ? b : a;
              if (ah >= 0) begin nreq = ah; nmode = m_dir ? M_UP : M_DOWN; end
              else if (bh >= 0) begin nreq = bh; nmode = m_dir ? M_DOWN : M_UP; ndir = !m_dir; end
              else nmode = M_IDLE;
            end else ncnt = m_cnt + 1;
          end
        endcase
      end
      for (int f = 0; f < NF; f++) if (setm[f]) m_pend[f] = 1'b1;
      if (clr >= 0) m_pend[clr] = 1'b0;
      m_mode = nmode; m_req = nreq; m_dir = ndir; m_cnt = ncnt;
      m_door = (nmode == M_DOOR);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_req",  bus.requested_floor, m_req);
      check("model_pend", pend, m_pend_vec());
      check("model_dir",  dir_up, m_dir);
      check("model_door", door_open, m_door);
    end
  end

  // ---------------- helpers ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1; btn = '0;
    step(3);
    rst = 1'b0;
  endtask

  task automatic wait_req(input int val, input int budget, input string name);
    int n = 0;
    while (bus.requested_floor !== 4'(val) && n < budget) begin step(1); n++; end
    check(name, bus.requested_floor, val);
  endtask

  task automatic wait_door(input logic val, input int budget, input string name);
    int n = 0;
    while (door_open !== val && n < budget) begin step(1); n++; end
    check(name, door_open, val);
  endtask

  typedef struct {
    logic [NF-1:0] btn;
    logic [3:0]    cur;
    logic          idle;
    logic [3:0]    req;
    logic [NF-1:0] pend;
    logic          dir;
    logic          door;
  } vec_t;

  vec_t tbl [14];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int door_len, tmr, r;
    bit leaked;

    // press btn[3] at floor 0, car arrives, full dwell, back to idle
    tbl[0] = '{10'h000, 4'd0, 1'b1, 4'd0, 10'h000, 1'b1, 1'b0};
    tbl[1] = '{10'h008, 4'd0, 1'b1, 4'd0, 10'h000, 1'b1, 1'b0};
    tbl[2] = '{10'h000, 4'd0, 1'b1, 4'd0, 10'h000, 1'b1, 1'b0};
    tbl[3] = '{10'h000, 4'd0, 1'b1, 4'd0, 10'h008, 1'b1, 1'b0};
    tbl[4] = '{10'h000, 4'd0, 1'b1, 4'd3, 10'h008, 1'b1, 1'b0};
    for (int i = 5; i < 13; i++) tbl[i] = '{10'h000, 4'd3, 1'b1, 4'd3, 10'h000, 1'b1, 1'b1};
    tbl[13] = '{10'h000, 4'd3, 1'b1, 4'd3, 10'h000, 1'b1, 1'b0};

    do_reset();
    step(1);
    chk_en = 1'b1;
    check("reset_req",  bus.requested_floor, 0);
    check("reset_pend", pend, 0);
    check("reset_dir",  dir_up, 1);
    check("reset_door", door_open, 0);
    step(10);
    check("quiet_req",  bus.requested_floor, 0);
    check("quiet_pend", pend, 0);

    for (int i = 0; i < 14; i++) begin
      btn = tbl[i].btn; cur = tbl[i].cur; idle = tbl[i].idle;
      step(1);
      check($sformatf("tbl%0d_req", i),  bus.requested_floor, tbl[i].req);
      check($sformatf("tbl%0d_pend", i), pend, tbl[i].pend);
      check($sformatf("tbl%0d_dir", i),  dir_up, tbl[i].dir);
      check($sformatf("tbl%0d_door", i), door_open, tbl[i].door);
    end

    // retarget: car at 2 heading to 7, a call at 5 pulls the target in
    do_reset(); cur = 4'd2; idle = 1'b1;
    btn = 10'h080; step(1); btn = '0;
    wait_req(7, 8, "retarget_first_7");
    cur = 4'd3; idle = 1'b0; btn = 10'h020; step(1); btn = '0;
    wait_req(5, 8, "retarget_to_5");
    cur = 4'd4; step(1);
    cur = 4'd5; idle = 1'b1;
    wait_door(1'b1, 6, "retarget_door_open");
    check("retarget_pend_7_left", pend, 10'h080);
    wait_door(1'b0, 20, "retarget_door_close");
    check("retarget_resume_7", bus.requested_floor, 7);
    check("retarget_dir_up", dir_up, 1);

    // SCAN: at 4 with calls {6,1} -> serve 6, then reverse to 1
    do_reset(); cur = 4'd4; idle = 1'b1;
    btn = 10'h042; step(1); btn = '0;
    wait_req(6, 8, "scan_first_6");
    check("scan_dir_up", dir_up, 1);
    cur = 4'd6;
    wait_door(1'b1, 6, "scan_door_open");
    wait_door(1'b0, 20, "scan_door_close");
    check("scan_reverse_dir", dir_up, 0);
    check("scan_then_1", bus.requested_floor, 1);
    check("scan_pend_1", pend, 10'h002);

    // held button gives one call; press at door floor restarts dwell
    do_reset(); cur = 4'd5; idle = 1'b0;
    btn = 10'h004; step(100);
    check("hold_single_call", pend, 10'h004);
    check("hold_target_2", bus.requested_floor, 2);
    btn = '0; step(2);
    cur = 4'd2; idle = 1'b1;
    wait_door(1'b1, 6, "dwell_door_open");
    btn = 10'h004; step(1); btn = '0;
    door_len = 2; leaked = 1'b0;
    while (door_open === 1'b1 && door_len < 40) begin
      if (pend[2]) leaked = 1'b1;
      step(1);
      if (door_open === 1'b1) door_len++;
    end
    check("dwell_restart_len", door_len, 11);
    check("dwell_press_absorbed", leaked, 0);
    step(5);
    check("hold_no_second_call", pend, 0);

    // reset mid-sweep drops everything
    do_reset(); cur = 4'd9; idle = 1'b0;
    btn = 10'h094; step(1); btn = '0; step(4);
    check("midsweep_pend", pend, 10'h094);
    check("midsweep_req", bus.requested_floor, 7);
    check("midsweep_dir", dir_up, 0);
    rst = 1'b1; step(1);
    check("midreset_req",  bus.requested_floor, 0);
    check("midreset_pend", pend, 0);
    check("midreset_dir",  dir_up, 1);
    check("midreset_door", door_open, 0);
    rst = 1'b0; cur = 4'd0; idle = 1'b1; step(10);
    check("no_stale_pend", pend, 0);
    check("no_stale_req", bus.requested_floor, 0);

    // out-of-range position forces target 0, then service resumes
    btn = 10'h008; step(1); btn = '0; step(3);
    check("range_pre_req", bus.requested_floor, 3);
    cur = 4'd12; step(1);
    check("range_forced_0", bus.requested_floor, 0);
    cur = 4'd0;
    wait_req(3, 5, "range_resume_3");

    // randomized traffic with a simple car model, checked against the model
    do_reset(); cur = 4'd0; idle = 1'b1; tmr = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 5) == 0) begin
        r = $urandom_range(0, NF - 1);
        btn[r] = ~btn[r];
      end
      if (cyc % 700 == 350) begin
        cur = 4'd13; idle = 1'b1;
      end else if (cur != bus.requested_floor) begin
        idle = ($urandom_range(0, 9) == 0);
        if (tmr == 0) begin
          cur = (cur < bus.requested_floor) ? cur + 4'd1 : cur - 4'd1;
          tmr = $urandom_range(1, 3);
        end else tmr--;
      end else idle = 1'b1;
      step(1);
    end
    btn = '0;
    step(2);
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
